// File: rtl/regfile_dumper.sv
// regfile_dumper: walks the RV32I register file through a single read port
// and streams each register value, tagged with its index, over valid/ready.
// It only ever reads the register file.
//
// Stream handshake: dump_valid is high in SEND only; a beat transfers on a
// rising edge where dump_valid and dump_ready are both 1. While dump_valid is
// high, dump_addr/dump_data are held stable and dump_valid never drops before
// the transfer (abort is deferred until the beat is taken).
module regfile_dumper #(
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  output logic [4:0]  rf_addr,
  input  logic [31:0] rf_data,
  output logic        dump_valid,
  input  logic        dump_ready,
  output logic [4:0]  dump_addr,
  output logic [31:0] dump_data,
  output logic        busy,
  output logic        done,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_SEND = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [4:0] LP_FIRST = 5'(FIRST_REG);
  localparam logic [4:0] LP_LAST  = 5'(LAST_REG);

  state_t      r_state;
  logic [4:0]  r_idx;
  logic [4:0]  r_dump_addr;
  logic [31:0] r_dump_data;
  logic        w_handshake;

  assign w_handshake = (r_state == S_SEND) && dump_ready;

  // Dump sequencer: index walk, capture of the read port, stream handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_idx       <= 5'd0;
      r_dump_addr <= 5'd0;
      r_dump_data <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start && !abort) begin
            r_idx   <= LP_FIRST;
            r_state <= S_READ;
          end
        end
        S_READ: begin
          if (abort) begin
            r_state <= S_IDLE;
          end else begin
            // Value present on the port this cycle; a write landing on this
            // same edge is not visible yet, so the old contents are captured.
            r_dump_data <= rf_data;
            r_dump_addr <= r_idx;
            r_state     <= S_SEND;
          end
        end
        S_SEND: begin
          if (w_handshake) begin
            if (abort) begin
              r_state <= S_IDLE;
            end else if (r_idx == LP_LAST) begin
              r_state <= S_DONE;
            end else begin
              r_idx   <= r_idx + 5'd1;
              r_state <= S_READ;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Outputs decoded from registered state only; no input-to-output paths.
  assign rf_addr    = ((r_state == S_READ) || (r_state == S_SEND)) ? r_idx : 5'd0;
  assign dump_valid = (r_state == S_SEND);
  assign dump_addr  = r_dump_addr;
  assign dump_data  = r_dump_data;
  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_DONE);
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_regfile_dumper.sv
// Bench for regfile_dumper: a register-file model, a full-range instance and
// a single-register instance, scoreboards of expected beats, and directed
// steps with randomized register contents and backpressure.
module tb_regfile_dumper;

  logic clk = 1'b0;
  logic rst;

  // Instance A: default range 0..31
  logic        start_a, abort_a, dump_ready_a;
  logic [4:0]  rf_addr_a, dump_addr_a;
  logic [31:0] rf_data_a, dump_data_a;
  logic        dump_valid_a, busy_a, done_a;
  logic [1:0]  dbg_state_a;

  // Instance B: range 5..5
  logic        start_b, abort_b, dump_ready_b;
  logic [4:0]  rf_addr_b, dump_addr_b;
  logic [31:0] rf_data_b, dump_data_b;
  logic        dump_valid_b, busy_b, done_b;
  logic [1:0]  dbg_state_b;

  // Register file model shared by both instances
  logic [31:0] regs [32];
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;

  logic [36:0] exp_a[$];
  logic [36:0] exp_b[$];
  logic [31:0] snap [32];

  int n_checks = 0;
  int n_err    = 0;

  regfile_dumper u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort_a),
    .rf_addr(rf_addr_a), .rf_data(rf_data_a),
    .dump_valid(dump_valid_a), .dump_ready(dump_ready_a),
    .dump_addr(dump_addr_a), .dump_data(dump_data_a),
    .busy(busy_a), .done(done_a), .dbg_state(dbg_state_a)
  );

  regfile_dumper #(.FIRST_REG(5), .LAST_REG(5)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b),
    .rf_addr(rf_addr_b), .rf_data(rf_data_b),
    .dump_valid(dump_valid_b), .dump_ready(dump_ready_b),
    .dump_addr(dump_addr_b), .dump_data(dump_data_b),
    .busy(busy_b), .done(done_b), .dbg_state(dbg_state_b)
  );

  // Clock
  always #5 clk = ~clk;

  // Register file: x0 hardwired to zero, combinational read, write on edge
  assign rf_data_a = (rf_addr_a == 5'd0) ? 32'd0 : regs[rf_addr_a];
  assign rf_data_b = (rf_addr_b == 5'd0) ? 32'd0 : regs[rf_addr_b];

  always @(posedge clk) begin
    if (wr_en && (wr_addr != 5'd0)) regs[wr_addr] <= wr_data;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard A: every accepted beat must match the head of exp_a
  always @(posedge clk) begin
    if (!rst && dump_valid_a && dump_ready_a) begin
      chk("beat_expected_a", 64'(exp_a.size() > 0), 64'd1);
      if (exp_a.size() > 0) chk("beat_a", {dump_addr_a, dump_data_a}, exp_a.pop_front());
    end
  end

  // Scoreboard B
  always @(posedge clk) begin
    if (!rst && dump_valid_b && dump_ready_b) begin
      chk("beat_expected_b", 64'(exp_b.size() > 0), 64'd1);
      if (exp_b.size() > 0) chk("beat_b", {dump_addr_b, dump_data_b}, exp_b.pop_front());
    end
  end

  // Full-range dump on instance A. Beat b is valid for one cycle starting at
  // cycle 2+2b, except that beat s is stretched by L stalled cycles and every
  // later beat shifts by L. Optional register write during READ of wr_i and
  // optional stray starts (while busy and in DONE).
  task automatic run_dump_a(input int s, input int L, input int wr_i,
                            input logic [31:0] wr_v, input bit extra_starts);
    int n0;
    int done_cyc;
    int rd_cyc;
    bit vis;
    for (int b = 0; b < 32; b++) begin
      snap[b] = (b == 0) ? 32'd0 : regs[b];
      exp_a.push_back({5'(b), snap[b]});
    end
    n0       = 2 + 2 * s;
    done_cyc = 65 + L;
    rd_cyc   = 1 + 2 * wr_i + ((s >= 0 && wr_i > s) ? L : 0);
    start_a      = 1'b1;
    dump_ready_a = 1'b1;
    for (int n = 1; n <= done_cyc + 2; n++) begin
      @(negedge clk);
      start_a = extra_starts && (n == 10 || n == done_cyc);
      dump_ready_a = !(s >= 0 && n >= n0 && n < n0 + L);
      wr_en   = (wr_i >= 0) && (n == rd_cyc);
      wr_addr = 5'(wr_i);
      wr_data = wr_v;
      vis = 1'b0;
      for (int b = 0; b < 32; b++) begin
        int st;
        int ln;
        st = 2 + 2 * b + ((s >= 0 && b > s) ? L : 0);
        ln = 1 + ((b == s) ? L : 0);
        if (n >= st && n < st + ln) vis = 1'b1;
      end
      chk("busy_a", busy_a, 64'(n <= done_cyc));
      chk("done_a", done_a, 64'(n == done_cyc));
      chk("valid_a", dump_valid_a, 64'(vis));
      if (s >= 0 && n >= n0 && n < n0 + L) begin
        chk("stall_addr_a", dump_addr_a, 64'(s));
        chk("stall_data_a", dump_data_a, snap[s]);
      end
    end
    wr_en = 1'b0;
    chk("queue_empty_a", exp_a.size(), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    start_a = 0; abort_a = 0; dump_ready_a = 0;
    start_b = 0; abort_b = 0; dump_ready_b = 0;
    wr_en = 0; wr_addr = 0; wr_data = 0;
    for (int i = 0; i < 32; i++) regs[i] = 32'h1000_0000 + i;
    regs[0] = 32'd0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", dump_valid_a, 64'd0);
    chk("rst_busy", busy_a, 64'd0);
    chk("rst_done", done_a, 64'd0);
    chk("rst_rf_addr", rf_addr_a, 64'd0);
    chk("rst_dump_addr", dump_addr_a, 64'd0);
    chk("rst_dump_data", dump_data_a, 64'd0);
    chk("rst_busy_b", busy_b, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", busy_a, 64'd0);

    // Full dump with the preloaded pattern
    run_dump_a(-1, 0, -1, 32'd0, 1'b0);

    // Backpressure: 5 stalled cycles on beat 3, random contents
    for (int i = 1; i < 32; i++) regs[i] = $urandom;
    run_dump_a(3, 5, -1, 32'd0, 1'b0);

    // Random stall placement and length
    for (int i = 1; i < 32; i++) regs[i] = $urandom;
    run_dump_a(int'($urandom_range(0, 31)), int'($urandom_range(1, 8)), -1, 32'd0, 1'b0);

    // Starts while busy and during DONE are ignored
    run_dump_a(-1, 0, -1, 32'd0, 1'b1);

    // Concurrent write to x10 on the edge closing its READ: old value seen
    regs[10] = $urandom;
    run_dump_a(-1, 0, 10, 32'hDEAD_BEEF, 1'b0);
    chk("x10_written", regs[10], 32'hDEAD_BEEF);
    run_dump_a(-1, 0, -1, 32'd0, 1'b0);

    // Abort in SEND of beat 7 with ready low, then ready high
    for (int b = 0; b < 8; b++) exp_a.push_back({5'(b), (b == 0) ? 32'd0 : regs[b]});
    start_a = 1'b1;
    dump_ready_a = 1'b1;
    for (int n = 1; n <= 15; n++) begin
      @(negedge clk);
      start_a = 1'b0;
    end
    @(negedge clk);
    chk("abort_send_valid", dump_valid_a, 64'd1);
    chk("abort_send_addr", dump_addr_a, 64'd7);
    dump_ready_a = 1'b0;
    abort_a = 1'b1;
    @(negedge clk);
    chk("abort_hold_valid", dump_valid_a, 64'd1);
    chk("abort_hold_data", dump_data_a, regs[7]);
    dump_ready_a = 1'b1;
    @(negedge clk);
    chk("abort_idle_busy", busy_a, 64'd0);
    chk("abort_idle_valid", dump_valid_a, 64'd0);
    abort_a = 1'b0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk("abort_no_done", done_a, 64'd0);
      chk("abort_no_busy", busy_a, 64'd0);
    end
    chk("abort_queue_empty", exp_a.size(), 64'd0);

    // Abort in READ: nothing emitted, IDLE next cycle
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    chk("abort_read_busy", busy_a, 64'd1);
    chk("abort_read_valid", dump_valid_a, 64'd0);
    abort_a = 1'b1;
    @(negedge clk);
    chk("abort_read_idle", busy_a, 64'd0);
    abort_a = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("abort_read_novalid", dump_valid_a, 64'd0);
      chk("abort_read_nodone", done_a, 64'd0);
    end

    // Single-register range on instance B
    exp_b.push_back({5'd5, regs[5]});
    start_b = 1'b1;
    dump_ready_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    chk("b_read_busy", busy_b, 64'd1);
    chk("b_read_valid", dump_valid_b, 64'd0);
    @(negedge clk);
    chk("b_send_valid", dump_valid_b, 64'd1);
    chk("b_send_addr", dump_addr_b, 64'd5);
    @(negedge clk);
    chk("b_done", done_b, 64'd1);
    chk("b_done_valid", dump_valid_b, 64'd0);
    @(negedge clk);
    chk("b_idle_busy", busy_b, 64'd0);
    chk("b_idle_done", done_b, 64'd0);
    chk("b_queue_empty", exp_b.size(), 64'd0);

    // Asynchronous reset while beat 1 is waiting in SEND
    for (int i = 1; i < 32; i++) regs[i] = $urandom;
    exp_a.push_back({5'd0, 32'd0});
    start_a = 1'b1;
    dump_ready_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid_valid_before", dump_valid_a, 64'd1);
    chk("rst_mid_addr_before", dump_addr_a, 64'd1);
    dump_ready_a = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_valid", dump_valid_a, 64'd0);
    chk("rst_mid_busy", busy_a, 64'd0);
    chk("rst_mid_done", done_a, 64'd0);
    chk("rst_mid_rf_addr", rf_addr_a, 64'd0);
    chk("rst_mid_dump_addr", dump_addr_a, 64'd0);
    chk("rst_mid_dump_data", dump_data_a, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_queue_empty", exp_a.size(), 64'd0);
    @(negedge clk);
    run_dump_a(-1, 0, -1, 32'd0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_dumper.md
# regfile_dumper

Debug-side reader for the RV32I register file. On a start request it walks the register file through one read port, one register at a time. Each captured value goes out on a valid/ready stream tagged with its register index, for a debug link or trace buffer. It sits beside the core and shares a read address/data pair with decode through a debug mux, so it never writes the register file.

## Interface
Parameters:
- FIRST_REG, default 0: first register index dumped (0..31).
- LAST_REG, default 31: last register index dumped (FIRST_REG..31).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous and active-high.
- start  input  1  dump request; sampled only in IDLE.
- abort  input  1  cancel the dump in progress; level-sensitive.
- rf_addr  output  5  read address to the register file read port.
- rf_data  input  32  read data from the register file; combinational in rf_addr.
- dump_valid  output  1  beat available.
- dump_ready  input  1  consumer accepts the beat.
- dump_addr  output  5  register index of the current beat.
- dump_data  output  32  register contents of the current beat.
- busy  output  1  high whenever the block is not in IDLE.
- done  output  1  one-cycle pulse when a dump completes normally.

## Operation
- Internal state: a 5-bit index register `idx`.
- FSM states: IDLE, READ, SEND, DONE.
- **IDLE**
  - rf_addr=0, dump_valid=0, busy=0.
  - On start=1 and abort=0: idx<=FIRST_REG, then go to READ.
- **READ**
  - rf_addr=idx.
  - At the edge: dump_data<=rf_data, dump_addr<=idx, then go to SEND.
  - If abort=1 in READ: go to IDLE. Nothing is captured and no beat is produced.
- **SEND**
  - dump_valid=1, rf_addr holds idx.
  - dump_data and dump_addr stay stable until the handshake.
  - Handshake occurs at an edge where dump_valid and dump_ready are both 1.
  - On handshake:
    - if abort=1: go to IDLE;
    - else if idx==LAST_REG: go to DONE;
    - else idx<=idx+1 and go to READ.
  - Without a handshake: stay in SEND. Abort is deferred here; dump_valid never drops before its beat is accepted.
- **DONE**
  - done=1 for exactly this one cycle, then go to IDLE.
  - start is ignored in DONE.
- start is ignored in all states except IDLE. Raising start again while busy has no effect.
- Indexing rules:
  - idx never wraps. LAST_REG bounds the walk.
  - FIRST_REG==LAST_REG gives exactly one beat.
  - FIRST_REG==0 dumps x0, which always reads 0.
- The snapshot is not atomic. Each value is whatever the register file returns during that index's READ cycle. A write at the same edge is not seen; the old value is captured.
- Reset (asynchronous, at any time including mid-dump):
  - state=IDLE, idx=0, rf_addr=0, dump_valid=0, dump_addr=0, dump_data=0, busy=0, done=0.
  - Any in-flight beat is dropped.

## Timing
- start high in IDLE at edge k:
  - READ occupies cycle k+1;
  - first beat valid from cycle k+2.
- Each beat costs 2 cycles (READ + SEND) when dump_ready is held high. Each cycle dump_ready is low adds one cycle.
- Full dump of 32 registers with dump_ready=1 throughout:
  - beats are valid in cycles k+2, k+4, ..., k+64;
  - done=1 in cycle k+65;
  - busy=1 for cycles k+1..k+65;
  - IDLE from cycle k+66, when a new start is accepted.
- rf_data must settle within the READ cycle; there is no extra wait state.
- Outputs are registered or decoded from state only. No input reaches an output combinationally.

## Test plan
- **Full dump, default parameters.**
  - Stimulus: preload x1..x31 = 32'h1000_0000+i, dump_ready=1, start pulse at edge k.
  - Response: 32 beats with dump_addr 0..31; data 0 for x0, then 32'h1000_0001..32'h1000_001F; done pulses in cycle k+65; busy falls after.
- **Backpressure.**
  - Stimulus: hold dump_ready=0 for 5 cycles on beat 3.
  - Response: dump_valid stays 1 and dump_addr=3 and dump_data stay constant; beat 4 follows two cycles after acceptance; total completion delayed by exactly 5 cycles.
- **Abort.**
  - Abort asserted in SEND of beat 7 with dump_ready=0, then dump_ready=1: beat 7 is accepted, then the block returns to IDLE; no beat 8; done never pulses.
  - Abort asserted in READ: no beat is emitted and the block is in IDLE next cycle.
- **Range and start filtering.**
  - Stimulus: FIRST_REG=LAST_REG=5.
  - Response: a single beat with addr 5, then done.
  - Stimulus: a start pulse while busy and a start during DONE.
  - Response: both ignored; exactly one dump occurs.
- **Concurrent write.**
  - Stimulus: write x10=32'hDEAD_BEEF at the same edge that closes the READ cycle of index 10.
  - Response: the beat carries the old value. A second dump returns 32'hDEAD_BEEF.
- **Asynchronous reset mid-beat.**
  - Stimulus: assert rst between edges during SEND.
  - Response: dump_valid, busy, done, rf_addr, dump_addr and dump_data all go to 0 immediately, without a clock edge. After rst is released, a fresh start dumps from FIRST_REG.
